conv_result_writer: RTL
=======================

Name: conv_result_writer

Overview:
- Downstream end of the convolution datapath; consumes the pixel/weight beats fetched by the window address controller.
- Multiplies each beat and accumulates 25 taps per 5x5 window, then writes one output pixel to the output feature-map memory.
- Raster-increments the output address and signals window completion, so upstream launches the next window.
- Signals map completion after IMG_SIZE*IMG_SIZE output pixels.

Parameters:
IMG_SIZE, 28, output image side length (output pixels per map = IMG_SIZE*IMG_SIZE, max 1023)
TAPS, 25, beats per window (5x5 kernel)
DATA_W, 8, signed width of img_data and w_data
ACC_W, 24, signed accumulator / write-data width
RELU, 1, 1 = clamp negative results to 0 before write; 0 = write raw signed sum

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a new output map; sampled only in IDLE
out_base  in  10  output memory base address, latched on accepted start
data_valid  in  1  beat valid (driven by controller's data_out_ena)
img_data  in  DATA_W  signed pixel for current beat
w_data  in  DATA_W  signed weight for current beat
wr_en  out  1  one-cycle output-memory write strobe
wr_addr  out  10  output-memory write address
wr_data  out  ACC_W  output-memory write data
win_done  out  1  one-cycle pulse: window written, more windows remain
map_done  out  1  one-cycle pulse: last window of map written
busy  out  1  high in RUN

Behaviour:
- Reset (rst=1 at edge): state=IDLE; wr_en, win_done, map_done, busy = 0; wr_addr=0; wr_data=0; internal acc, tap_cnt, pix_cnt, prod_v, prod_r, out_addr = 0. Applies mid-window/mid-map too; partial sums are discarded, no write issued.
- States: IDLE, RUN.
- IDLE: data_valid ignored. start=1 -> out_addr<=out_base, acc<=0, tap_cnt<=0, pix_cnt<=0, state<=RUN. busy rises the next cycle.
- RUN: start is ignored.
- Stage 1 (RUN): prod_r <= signed img_data*w_data (2*DATA_W bits); prod_v <= data_valid. Outside RUN, prod_v <= 0.
- Stage 2, prod_v=1 and tap_cnt<TAPS-1: acc <= acc + sign-extended prod_r; tap_cnt++.
- Stage 2, prod_v=1 and tap_cnt==TAPS-1:
  - sum = acc + prod_r.
  - wr_data <= (RELU && sum<0) ? 0 : sum; wr_en <= 1; wr_addr <= out_addr.
  - acc<=0; tap_cnt<=0; out_addr++ (10-bit wrap allowed); pix_cnt++.
  - If pix_cnt==IMG_SIZE*IMG_SIZE-1: map_done<=1, state<=IDLE. Otherwise win_done<=1.
- wr_en, win_done, map_done are single-cycle pulses, default 0. wr_addr and wr_data hold their values between writes.
- Latency: 25th beat sampled at edge k -> wr_en, win_done/map_done high in the cycle after edge k+1.
- Beats may be gapped; only beats with data_valid=1 count.
- Back-to-back beats are accepted every cycle, including a new window's first beat in the cycle after the last beat.
- Arithmetic: max |sum| = 25*16384 = 409600 < 2^23, so ACC_W=24 never overflows; no saturation logic.
- Last window: the 25th beat is followed by the transition to IDLE. Any further data_valid is ignored.

Test Plan:
- Single window: IMG_SIZE=1, out_base=0x010, 25 beats img=1, w=1 -> one wr_en, wr_addr=0x010, wr_data=25, map_done pulse 2 cycles after last beat, no win_done, busy drops.
- Sign/ReLU: 25 beats img=-1, w=1. RELU=1 -> wr_data=0. RELU=0 -> wr_data=0xFFFFE7 (-25).
- Extreme: 25 beats img=-128, w=-128 -> wr_data=409600 (0x064000), no overflow.
- Full map: IMG_SIZE=2, out_base=0x3FE, 4 windows of 25 beats each with random gaps in data_valid.
  - Expected: writes at 0x3FE, 0x3FF, 0x000, 0x001 with correct sums.
  - Expected: win_done x3, map_done x1 on the 4th write.
- Control: start pulsed during RUN -> ignored, counts unchanged. data_valid in IDLE -> no write.
- Reset mid-window after 12 beats -> no write, all outputs 0. New start + 25 beats -> correct fresh sum at out_base.

Source files
------------

// File: rtl/conv_result_writer_if.sv
// Handshake/bus bundle between the window address controller side and the result writer.
// The master drives beats and start; the slave (the writer) returns the memory write port.
interface conv_result_writer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24
);
    logic                     start;
    logic [9:0]               out_base;
    logic                     data_valid;
    logic signed [DATA_W-1:0] img_data;
    logic signed [DATA_W-1:0] w_data;
    logic                     wr_en;
    logic [9:0]               wr_addr;
    logic [ACC_W-1:0]         wr_data;
    logic                     win_done;
    logic                     map_done;
    logic                     busy;

    modport master (
        output start, out_base, data_valid, img_data, w_data,
        input  wr_en, wr_addr, wr_data, win_done, map_done, busy
    );

    modport slave (
        input  start, out_base, data_valid, img_data, w_data,
        output wr_en, wr_addr, wr_data, win_done, map_done, busy
    );
endinterface

// File: rtl/conv_result_writer.sv
// Multiply-accumulate of TAPS beats per window, one output-memory write per window,
// raster output addressing and window/map completion pulses.
module conv_result_writer #(
    parameter int unsigned IMG_SIZE = 28,
    parameter int unsigned TAPS     = 25,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 24,
    parameter bit          RELU     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_result_writer_if.slave   bus
);
    localparam int unsigned NumPix = IMG_SIZE * IMG_SIZE;
    localparam int unsigned TapW   = $clog2(TAPS);
    localparam int unsigned ProdW  = 2 * DATA_W;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                   state_q, state_d;
    logic signed [ProdW-1:0]  prod_r_q, prod_r_d;
    logic                     prod_v_q, prod_v_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [TapW-1:0]          tap_cnt_q, tap_cnt_d;
    logic [9:0]               pix_cnt_q, pix_cnt_d;
    logic [9:0]               out_addr_q, out_addr_d;
    logic                     wr_en_q, wr_en_d;
    logic [9:0]               wr_addr_q, wr_addr_d;
    logic [ACC_W-1:0]         wr_data_q, wr_data_d;
    logic                     win_done_q, win_done_d;
    logic                     map_done_q, map_done_d;

    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;

    assign prod_ext = {{(ACC_W - ProdW){prod_r_q[ProdW-1]}}, prod_r_q};
    assign sum      = acc_q + prod_ext;

    always_comb begin
        state_d    = state_q;
        prod_r_d   = prod_r_q;
        prod_v_d   = 1'b0;
        acc_d      = acc_q;
        tap_cnt_d  = tap_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        out_addr_d = out_addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        win_done_d = 1'b0;
        map_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    out_addr_d = bus.out_base;
                    acc_d      = '0;
                    tap_cnt_d  = '0;
                    pix_cnt_d  = '0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                prod_r_d = bus.img_data * bus.w_data;
                prod_v_d = bus.data_valid;
                if (prod_v_q) begin
                    if (tap_cnt_q == TapW'(TAPS - 1)) begin
                        // Last tap: the write uses the sum including this product.
                        wr_data_d  = (RELU && sum[ACC_W-1]) ? '0 : sum;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = out_addr_q;
                        acc_d      = '0;
                        tap_cnt_d  = '0;
                        out_addr_d = out_addr_q + 10'd1;
                        pix_cnt_d  = pix_cnt_q + 10'd1;
                        if (pix_cnt_q == 10'(NumPix - 1)) begin
                            map_done_d = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            win_done_d = 1'b1;
                        end
                    end else begin
                        acc_d     = sum;
                        tap_cnt_d = tap_cnt_q + TapW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            prod_r_q   <= '0;
            prod_v_q   <= 1'b0;
            acc_q      <= '0;
            tap_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            out_addr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            win_done_q <= 1'b0;
            map_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prod_r_q   <= prod_r_d;
            prod_v_q   <= prod_v_d;
            acc_q      <= acc_d;
            tap_cnt_q  <= tap_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            out_addr_q <= out_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            win_done_q <= win_done_d;
            map_done_q <= map_done_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.win_done = win_done_q;
    assign bus.map_done = map_done_q;
    assign bus.busy     = (state_q == StRun);
endmodule
